// File: rtl/xbar_cfg_pkg.sv
// rtl/xbar_cfg_pkg.sv - shared sizes and FSM state type for the crossbar config loader
package xbar_cfg_pkg;

    localparam int NUM_INS  = 33;
    localparam int NUM_OUTS = 40;
    localparam int SEL_W    = 6;
    localparam int BEAT_W   = 8;

    localparam int CFG_W  = NUM_OUTS * SEL_W;
    localparam int NBEATS = CFG_W / BEAT_W;
    localparam int CNT_W  = $clog2(NBEATS + 1);

    // ST_PARITY is only reachable when XBAR_CFG_PARITY_EN is defined.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_PARITY = 2'd2,
        ST_CHECK  = 2'd3
    } cfg_state_t;

endpackage

// File: rtl/xbar_sel_range_check.sv
// rtl/xbar_sel_range_check.sv - combinational check that every selector addresses a real crossbar input
//  shadow     in   CFG_W  candidate configuration, selector j = [j*SEL_W +: SEL_W]
//  all_legal  out  1      high when every selector is < NUM_INS
module xbar_sel_range_check
    import xbar_cfg_pkg::*;
(
    input  logic [CFG_W-1:0] shadow,
    output logic             all_legal
);

    always_comb begin
        all_legal = 1'b1;
        for (int j = 0; j < NUM_OUTS; j++) begin
            // One extra bit so a NUM_INS of 2**SEL_W cannot wrap to zero.
            if ({1'b0, shadow[j*SEL_W +: SEL_W]} >= (SEL_W + 1)'(NUM_INS)) begin
                all_legal = 1'b0;
            end
        end
    end

endmodule

// File: rtl/xbar_cfg_loader.sv
// rtl/xbar_cfg_loader.sv - beat-wise crossbar config loader with range check and atomic commit
//  Optional feature macro: XBAR_CFG_PARITY_EN (adds a trailing parity beat per load).
//  clk             in   1       clock
//  reset           in   1       synchronous, active-high
//  io_cfg_start    in   1       begin a new load; aborts a load in progress
//  io_cfg_valid    in   1       beat valid
//  io_cfg_ready    out  1       beat accepted when valid && ready
//  io_cfg_data     in   BEAT_W  beat payload, beat 0 fills the LSBs
//  io_mux_configs  out  CFG_W   active crossbar selectors
//  io_cfg_busy     out  1       loader not idle
//  io_cfg_done     out  1       pulse in the first cycle a new config is visible
//  io_cfg_err      out  1       sticky error, cleared by start or reset
module xbar_cfg_loader
    import xbar_cfg_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              io_cfg_start,
    input  logic              io_cfg_valid,
    output logic              io_cfg_ready,
    input  logic [BEAT_W-1:0] io_cfg_data,
    output logic [CFG_W-1:0]  io_mux_configs,
    output logic              io_cfg_busy,
    output logic              io_cfg_done,
    output logic              io_cfg_err
);

    cfg_state_t        state;
    cfg_state_t        next_state;
    logic [CNT_W-1:0]  cnt;
    logic [CFG_W-1:0]  shadow;
    logic [CFG_W-1:0]  active;
    logic              done_q;
    logic              err_q;

    logic              all_legal;
    logic              beat_fire;
    logic              load_beat;
    logic              cnt_clr;
    logic              commit;
    logic              set_err;
    logic              clr_err;

    xbar_sel_range_check u_range_check (
        .shadow    (shadow),
        .all_legal (all_legal)
    );

    assign io_cfg_ready   = (state == ST_LOAD || state == ST_PARITY) && !io_cfg_start;
    assign io_cfg_busy    = (state != ST_IDLE);
    assign io_cfg_done    = done_q;
    assign io_cfg_err     = err_q;
    assign io_mux_configs = active;

    assign beat_fire = io_cfg_valid && io_cfg_ready;
    assign load_beat = beat_fire && (state == ST_LOAD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cnt_clr    = 1'b0;
        commit     = 1'b0;
        set_err    = 1'b0;
        clr_err    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (io_cfg_start) begin
                    next_state = ST_LOAD;
                    cnt_clr    = 1'b1;
                    clr_err    = 1'b1;
                end
            end
            ST_LOAD: begin
                if (io_cfg_start) begin
                    cnt_clr = 1'b1;
                    clr_err = 1'b1;
                end else if (beat_fire && cnt == CNT_W'(NBEATS - 1)) begin
`ifdef XBAR_CFG_PARITY_EN
                    next_state = ST_PARITY;
`else
                    next_state = ST_CHECK;
`endif
                end
            end
`ifdef XBAR_CFG_PARITY_EN
            ST_PARITY: begin
                if (io_cfg_start) begin
                    next_state = ST_LOAD;
                    cnt_clr    = 1'b1;
                    clr_err    = 1'b1;
                end else if (beat_fire) begin
                    if (io_cfg_data[0] == ^shadow) begin
                        next_state = ST_CHECK;
                    end else begin
                        next_state = ST_IDLE;
                        set_err    = 1'b1;
                    end
                end
            end
`endif
            ST_CHECK: begin
                // The check always finishes; a start here only redirects to LOAD afterwards.
                if (all_legal) begin
                    commit = 1'b1;
                end else begin
                    set_err = 1'b1;
                end
                if (io_cfg_start) begin
                    next_state = ST_LOAD;
                    cnt_clr    = 1'b1;
                    clr_err    = 1'b1;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            shadow <= '0;
            active <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= commit;
            if (cnt_clr) begin
                cnt <= '0;
            end else if (load_beat) begin
                cnt <= cnt + 1'b1;
            end
            if (load_beat) begin
                shadow[cnt*BEAT_W +: BEAT_W] <= io_cfg_data;
            end
            if (commit) begin
                active <= shadow;
            end
            // A failed check in the same cycle as a new start still reports its error.
            if (set_err) begin
                err_q <= 1'b1;
            end else if (clr_err) begin
                err_q <= 1'b0;
            end
        end
    end

endmodule
